// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch slice.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Small circular queue of fetched {pc, instr} pairs between memory and Decode.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_data = mem_q[rd_q];
  assign count     = cnt_q;
  assign empty     = (cnt_q == '0);

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: request FSM, PCF, prefetch queue and the Fetch/Decode pipeline register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pcf_q, pcf_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   instrd_q, instrd_d;
  logic [31:0]   pcd_q, pcd_d;
  logic [31:0]   pcplus4d_q, pcplus4d_d;
  logic          validd_q, validd_d;

  logic          xfer, q_push, q_pop, q_empty;
  logic [CW-1:0] q_count, count_after;
  fetch_entry_t  q_head, q_wdata;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .flush     (PCSrcE),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign imem.imem_req  = (state_q != IDLE);
  assign imem.imem_addr = addr_q;
  assign xfer           = (state_q != IDLE) && imem.imem_ready;

  assign InstrD   = instrd_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4d_q;
  assign ValidD   = validd_q;

  always_comb begin
    q_pop         = !PCSrcE && !FlushD && !StallD && !q_empty;
    q_push        = xfer && (state_q == WAIT) && !PCSrcE;
    q_wdata.pc    = pcf_q;
    q_wdata.instr = imem.imem_rdata;
    count_after   = PCSrcE ? '0 : (q_count - CW'(q_pop) + CW'(q_push));
  end

  // Space is judged after this cycle's pop/push so a drained queue refills without a gap.
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    if (PCSrcE) begin
      pcf_d = {PCTargetE[31:2], 2'b00};
    end
    unique case (state_q)
      IDLE: begin
        if (count_after < CW'(QDEPTH)) state_d = WAIT;
      end
      WAIT: begin
        if (xfer) begin
          if (!PCSrcE) pcf_d = pcf_q + 32'd4;
          state_d = (count_after < CW'(QDEPTH)) ? WAIT : IDLE;
        end else if (PCSrcE) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem.imem_ready) state_d = (count_after < CW'(QDEPTH)) ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The bus address only moves when a fresh request is launched or the current one retires.
    addr_d = (state_d == WAIT) ? pcf_d : addr_q;
  end

  always_comb begin
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (PCSrcE || FlushD) begin
      validd_d = 1'b0;
      instrd_d = NOP_INSTR;
    end else if (!StallD) begin
      if (!q_empty) begin
        validd_d   = 1'b1;
        instrd_d   = q_head.instr;
        pcd_d      = q_head.pc;
        pcplus4d_d = q_head.pc + 32'd4;
      end else begin
        validd_d = 1'b0;
        instrd_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pcf_q      <= RESET_PC;
      addr_q     <= RESET_PC;
      instrd_q   <= NOP_INSTR;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      addr_q     <= addr_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          QD  = 2;

  logic        clk;
  logic        reset;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Model: a list of fetched words plus one outstanding-request record.
  entry_t      m_q[$];
  logic [31:0] m_pcf   = 32'h0;
  logic        m_req   = 1'b0;
  logic [31:0] m_addr  = 32'h0;
  logic        m_stale = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pcd   = 32'h0;
  logic [31:0] m_pc4   = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return a ^ 32'hA5C3_0013;
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic fl, input logic pc,
                            input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    entry_t e;
    logic   done;
    if (rst) begin
      m_q.delete();
      m_pcf = 32'h0; m_req = 1'b0; m_addr = 32'h0; m_stale = 1'b0;
      m_valid = 1'b0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0;
      return;
    end
    done = m_req && rdy;
    if (pc || fl) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!st) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_valid = 1'b1; m_instr = e.instr; m_pcd = e.pc; m_pc4 = e.pc + 32'd4;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    if (done && !m_stale && !pc) begin
      m_q.push_back('{m_pcf, rd});
      m_pcf = m_pcf + 32'd4;
    end
    if (pc) begin
      m_q.delete();
      m_pcf = {tgt[31:2], 2'b00};
    end
    if (m_req && !done) begin
      if (pc) m_stale = 1'b1;
    end else if (m_q.size() < QD) begin
      m_req = 1'b1; m_addr = m_pcf; m_stale = 1'b0;
    end else begin
      m_req = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_eq("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) check_eq("imem_addr", bus.imem_addr, m_addr);
    check_eq("ValidD", 32'(ValidD), 32'(m_valid));
    check_eq("InstrD", InstrD, m_instr);
    check_eq("PCD", PCD, m_pcd);
    check_eq("PCPlus4D", PCPlus4D, m_pc4);
  endtask

  task automatic step(input logic rst, input logic st, input logic fl, input logic pc,
                      input logic [31:0] tgt, input logic rdy);
    logic [31:0] rd;
    rd = word_at(m_addr);
    reset = rst; StallD = st; FlushD = fl; PCSrcE = pc; PCTargetE = tgt;
    bus.imem_ready = rdy;
    bus.imem_rdata = rd;
    model_step(rst, st, fl, pc, tgt, rdy, rd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("rst_req", 32'(bus.imem_req), 32'h0);
    check_eq("rst_valid", 32'(ValidD), 32'h0);
    check_eq("rst_instr", InstrD, NOP);
    check_eq("rst_pcd", PCD, 32'h0);
    check_eq("rst_pc4", PCPlus4D, 32'h0);
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;

    // Zero-wait fetch after reset, then a 3-cycle memory stall.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("first_req", 32'(bus.imem_req), 32'h1);
    check_eq("first_addr", bus.imem_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("valid_c1", 32'(ValidD), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("valid_c2", 32'(ValidD), 32'h1);
    check_eq("pcd_0", PCD, 32'h0);
    check_eq("instr_0", InstrD, 32'h0050_0093);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_eq("wait_addr", bus.imem_addr, 32'h8);
      if (k == 0) check_eq("pcd_4", PCD, 32'h4);
      else        check_eq("wait_bubble", 32'(ValidD), 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("after_wait_pcd8", PCD, 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("no_dup_pcdC", PCD, 32'hC);

    // Decode stall: queue fills, requests stop, then drains back-to-back.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("stall_instr", InstrD, 32'h0050_0093);
      check_eq("stall_req", 32'(bus.imem_req), 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("rel_pcd4", PCD, 32'h4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("rel_pcd8", PCD, 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("rel_pcdC", PCD, 32'hC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("rel_pcd10", PCD, 32'h10);
    check_eq("rel_valid", 32'(ValidD), 32'h1);

    // Redirect while a request is outstanding.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
    check_eq("disc_addr_stale", bus.imem_addr, 32'h0);
    check_eq("disc_valid", 32'(ValidD), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_addr", bus.imem_addr, 32'h100);
    check_eq("redir_valid", 32'(ValidD), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_pcd", PCD, 32'h100);

    // Reset coincident with a completion.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("midrst_req", 32'(bus.imem_req), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("midrst_addr", bus.imem_addr, 32'h0);
    check_eq("midrst_valid", 32'(ValidD), 32'h0);

    // Wrap of PCF past the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int unsigned i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 7),
           ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom(),
           ($urandom_range(0, 99) < 60));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
